// File: rtl/alu_control_unit_pkg.sv
// Shared constants for the ALU control unit: opcode map, ALU operation codes,
// FSM state encoding and the decoded-instruction bundle.
package alu_ctrl_pkg;

   localparam logic [3:0] OPC_ADD   = 4'd0;
   localparam logic [3:0] OPC_SUB   = 4'd1;
   localparam logic [3:0] OPC_X2    = 4'd2;
   localparam logic [3:0] OPC_X4    = 4'd3;
   localparam logic [3:0] OPC_MUL   = 4'd4;
   localparam logic [3:0] OPC_DIV16 = 4'd5;
   localparam logic [3:0] OPC_INC   = 4'd6;
   localparam logic [3:0] OPC_DEC   = 4'd7;
   localparam logic [3:0] OPC_LDAC  = 4'd8;
   localparam logic [3:0] OPC_STAC  = 4'd9;
   localparam logic [3:0] OPC_CLAC  = 4'd10;
   localparam logic [3:0] OPC_JMPN  = 4'd11;
   localparam logic [3:0] OPC_NOP   = 4'd12;
   localparam logic [3:0] OPC_ILL   = 4'd13;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_X2    = 3'b010;
   localparam logic [2:0] ALU_X4    = 3'b011;
   localparam logic [2:0] ALU_MUL   = 3'b100;
   localparam logic [2:0] ALU_DIV16 = 3'b101;
   localparam logic [2:0] ALU_INC   = 3'b110;
   localparam logic [2:0] ALU_DEC   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RDOP = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic is_alu;
      logic is_ldac;
      logic is_stac;
      logic is_clac;
      logic is_jmpn;
      logic is_illegal;
   } decode_t;

endpackage

// File: rtl/alu_control_unit_if.sv
// Instruction handshake between fetch/decode (master) and the ALU control unit (slave).
interface alu_control_unit_if #(
   parameter int OPC_W     = 4,
   parameter int REG_SEL_W = 4
);

   logic                 instr_valid;
   logic                 instr_ready;
   logic [OPC_W-1:0]     instr_opcode;
   logic [REG_SEL_W-1:0] instr_reg_sel;

   modport master (
      output instr_valid,
      output instr_opcode,
      output instr_reg_sel,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_opcode,
      input  instr_reg_sel,
      output instr_ready
   );

endinterface

// File: rtl/alu_control_unit_decode.sv
// Combinational opcode classifier; NOP is the only opcode that raises no flag.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opcode,
   output decode_t          dec
);

   always_comb begin
      dec            = '0;
      dec.is_alu     = (opcode <= OPC_W'(OPC_DEC));
      dec.is_ldac    = (opcode == OPC_W'(OPC_LDAC));
      dec.is_stac    = (opcode == OPC_W'(OPC_STAC));
      dec.is_clac    = (opcode == OPC_W'(OPC_CLAC));
      dec.is_jmpn    = (opcode == OPC_W'(OPC_JMPN));
      dec.is_illegal = (opcode >= OPC_W'(OPC_ILL));
   end

endmodule

// File: rtl/alu_control_unit.sv
// Sequences one instruction at a time through IDLE -> RDOP -> EXEC -> DONE,
// owning the accumulator (ALU operand 1) and the registered negative flag.
module alu_control_unit
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int REG_SEL_W = 4,
   parameter int OPC_W     = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   alu_control_unit_if.slave    fetch,
   output logic [REG_SEL_W-1:0] reg_rd_sel,
   input  logic [DATA_W-1:0]    reg_rd_data,
   output logic                 reg_wr_en,
   output logic [REG_SEL_W-1:0] reg_wr_sel,
   output logic [DATA_W-1:0]    reg_wr_data,
   output logic [2:0]           alu_operation,
   output logic [DATA_W-1:0]    alu_in1,
   output logic [DATA_W-1:0]    alu_in2,
   input  logic [DATA_W-1:0]    alu_out,
   input  logic                 alu_neg,
   output logic [DATA_W-1:0]    ac_out,
   output logic                 n_flag,
   output logic                 done,
   output logic                 branch_taken,
   output logic                 illegal
);

   logic [1:0]           state;
   logic [OPC_W-1:0]     opc_q;
   logic [REG_SEL_W-1:0] sel_q;
   logic [DATA_W-1:0]    operand;
   logic [DATA_W-1:0]    ac;
   logic                 n;
   logic                 accept;
   decode_t              dec;

   alu_ctrl_decode #(
      .OPC_W (OPC_W)
   ) u_decode (
      .opcode (opc_q),
      .dec    (dec)
   );

   assign fetch.instr_ready = (state == ST_IDLE);
   assign accept            = fetch.instr_valid & fetch.instr_ready;

   // Instruction capture and sequencing; every instruction takes the same path.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         opc_q <= '0;
         sel_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  opc_q <= fetch.instr_opcode;
                  sel_q <= fetch.instr_reg_sel;
                  state <= ST_RDOP;
               end
            end
            ST_RDOP: state <= ST_EXEC;
            ST_EXEC: state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Operand is latched for all opcodes so latency never depends on the opcode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         operand <= '0;
      end else if (state == ST_RDOP) begin
         operand <= reg_rd_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ac <= '0;
         n  <= 1'b0;
      end else if (state == ST_EXEC) begin
         if (dec.is_alu) begin
            ac <= alu_out;
            n  <= alu_neg;
         end else if (dec.is_ldac) begin
            ac <= operand;
            n  <= operand[DATA_W-1];
         end else if (dec.is_clac) begin
            ac <= '0;
            n  <= 1'b0;
         end
      end
   end

   assign reg_rd_sel    = sel_q;
   assign reg_wr_en     = (state == ST_EXEC) && dec.is_stac;
   assign reg_wr_sel    = sel_q;
   assign reg_wr_data   = ac;

   // The ALU sees a live operation only while its result is being committed.
   assign alu_operation = ((state == ST_EXEC) && dec.is_alu) ? opc_q[2:0] : ALU_ADD;
   assign alu_in1       = ac;
   assign alu_in2       = operand;

   assign ac_out        = ac;
   assign n_flag        = n;
   assign done          = (state == ST_DONE);
   assign branch_taken  = (state == ST_DONE) && dec.is_jmpn && n;
   assign illegal       = (state == ST_DONE) && dec.is_illegal;

endmodule
